// File: rtl/odu_cfg_ctr_gen2_pkg.sv
// Shared constants for the ODU gen-data config/status register bank.
// Word map, CTRL/STATUS bit positions and the default ID word.
package odu_cfg_pkg;

    localparam int ADDR_ID     = 'h00;
    localparam int ADDR_CTRL   = 'h01;
    localparam int ADDR_STATUS = 'h02;
    localparam int ENA_BASE    = 'h04;
    localparam int TYP_BASE    = 'h0C;
    localparam int ERR_BASE    = 'h14;

    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_GEN  = 0;
    localparam int STAT_RUN  = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_DONE = 3;
    localparam int STAT_LOCK = 4;

    localparam logic [15:0] ID_DEFAULT = 16'h0D02;

endpackage

// File: rtl/odu_cfg_ctr_gen2_if.sv
// Async-SRAM-style cfg bus (active-low cs/we/oe) with registered read data.
// The CPU side is the master, the register bank is the slave.
interface odu_cfg_ctr_gen2_if #(
    parameter int DATA_WIDTH_CFG = 16,
    parameter int ADDR_WIDTH_CFG = 5
);
    logic                      cfg_n_cs;
    logic                      cfg_n_we;
    logic                      cfg_n_oe;
    logic [ADDR_WIDTH_CFG-1:0] cfg_addr;
    logic [DATA_WIDTH_CFG-1:0] cfg_din;
    logic [DATA_WIDTH_CFG-1:0] cfg_dout;
    logic                      cfg_dout_vld;

    modport master (
        output cfg_n_cs, cfg_n_we, cfg_n_oe, cfg_addr, cfg_din,
        input  cfg_dout, cfg_dout_vld
    );

    modport slave (
        input  cfg_n_cs, cfg_n_we, cfg_n_oe, cfg_addr, cfg_din,
        output cfg_dout, cfg_dout_vld
    );
endinterface

// File: rtl/odu_cfg_ctr_gen2_sticky.sv
// Sticky bit vector: set vector ORs in, clear vector removes (W1C).
// A bit set and cleared in the same cycle ends up set.
module odu_sticky_w1c #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= (q & ~clr) | set;
    end
endmodule

// File: rtl/odu_cfg_ctr_gen2.sv
// CPU-side config/status bank for the ODU channel data generator:
// channel enable/type words, run control, sticky errors and IRQ.
module odu_cfg_ctr_gen2
    import odu_cfg_pkg::*;
#(
    parameter int DATA_WIDTH_CFG = 16,
    parameter int ADDR_WIDTH_CFG = 5,
    parameter int NUM_CH         = 80,
    parameter logic [DATA_WIDTH_CFG-1:0] ID_VALUE =
        DATA_WIDTH_CFG'(ID_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    odu_cfg_ctr_gen2_if.slave cfg,
    input  logic [NUM_CH-1:0] i_error_chid,
    input  logic              status_gen_data,
    output logic [NUM_CH-1:0] cfg_enable_chid,
    output logic [NUM_CH-1:0] cfg_type_chid,
    output logic              cfg_start_pulse,
    output logic              cfg_run,
    output logic              o_irq
);
    localparam int DW = DATA_WIDTH_CFG;
    localparam int AW = ADDR_WIDTH_CFG;
    localparam int NW = (NUM_CH + DW - 1) / DW;
    localparam int PW = NW * DW;

    logic              wr, rd, ctrl_wr, stat_wr;
    logic              run_q, irq_en_q, gen_q, pulse_q, irq_q;
    logic              ena_hit, typ_hit, lock_set, done_set;
    logic              gen_fall, start_go, stop_req, run_nxt;
    logic [1:0]        stk_q, stk_clr;
    logic [NUM_CH-1:0] ena_q, typ_q, err_q;
    logic [NUM_CH-1:0] ena_nxt, typ_nxt, err_clr;
    logic [PW-1:0]     ena_pad, typ_pad, err_pad;
    logic [DW-1:0]     rd_data;

    assign wr      = !cfg.cfg_n_cs && !cfg.cfg_n_we;
    assign rd      = !cfg.cfg_n_cs && !cfg.cfg_n_oe;
    assign ctrl_wr = wr && cfg.cfg_addr == AW'(ADDR_CTRL);
    assign stat_wr = wr && cfg.cfg_addr == AW'(ADDR_STATUS);

    // Per-bit write decode keeps bits >= NUM_CH out of every register.
    always_comb begin
        ena_nxt = ena_q;
        typ_nxt = typ_q;
        err_clr = '0;
        ena_hit = 1'b0;
        typ_hit = 1'b0;
        for (int k = 0; k < NW; k++) begin
            if (wr && cfg.cfg_addr == AW'(ENA_BASE + k)) ena_hit = 1'b1;
            if (wr && cfg.cfg_addr == AW'(TYP_BASE + k)) typ_hit = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr && cfg.cfg_addr == AW'(ENA_BASE + i / DW))
                ena_nxt[i] = cfg.cfg_din[i % DW];
            if (wr && cfg.cfg_addr == AW'(TYP_BASE + i / DW))
                typ_nxt[i] = cfg.cfg_din[i % DW];
            if (wr && cfg.cfg_addr == AW'(ERR_BASE + i / DW))
                err_clr[i] = cfg.cfg_din[i % DW];
        end
    end

    assign gen_fall = gen_q && !status_gen_data;
    assign stop_req = ctrl_wr && cfg.cfg_din[CTRL_STOP];
    assign start_go = ctrl_wr && cfg.cfg_din[CTRL_START]
                   && !stop_req && !run_q;
    assign done_set = gen_fall && run_q;
    assign lock_set = run_q && (ena_hit || typ_hit);
    assign stk_clr  = stat_wr ? {cfg.cfg_din[STAT_LOCK],
                                 cfg.cfg_din[STAT_DONE]} : 2'b00;

    always_comb begin
        run_nxt = run_q;
        if (stop_req)      run_nxt = 1'b0;
        else if (start_go) run_nxt = 1'b1;
        else if (done_set) run_nxt = 1'b0;
    end

    odu_sticky_w1c #(.WIDTH(NUM_CH)) u_err (
        .clk (clk),
        .rst (rst),
        .set (i_error_chid),
        .clr (err_clr),
        .q   (err_q)
    );

    // stk_q = {WR_LOCK_ERR, DONE}
    odu_sticky_w1c #(.WIDTH(2)) u_stat (
        .clk (clk),
        .rst (rst),
        .set ({lock_set, done_set}),
        .clr (stk_clr),
        .q   (stk_q)
    );

    always_comb begin
        ena_pad = '0;
        typ_pad = '0;
        err_pad = '0;
        ena_pad[NUM_CH-1:0] = ena_q;
        typ_pad[NUM_CH-1:0] = typ_q;
        err_pad[NUM_CH-1:0] = err_q;
        rd_data = '0;
        if (cfg.cfg_addr == AW'(ADDR_ID)) rd_data = ID_VALUE;
        if (cfg.cfg_addr == AW'(ADDR_CTRL))
            rd_data[CTRL_IRQ_EN] = irq_en_q;
        if (cfg.cfg_addr == AW'(ADDR_STATUS)) begin
            rd_data[STAT_GEN]  = status_gen_data;
            rd_data[STAT_RUN]  = run_q;
            rd_data[STAT_ERR]  = |err_q;
            rd_data[STAT_DONE] = stk_q[0];
            rd_data[STAT_LOCK] = stk_q[1];
        end
        for (int k = 0; k < NW; k++) begin
            if (cfg.cfg_addr == AW'(ENA_BASE + k)) rd_data = ena_pad[k*DW +: DW];
            if (cfg.cfg_addr == AW'(TYP_BASE + k)) rd_data = typ_pad[k*DW +: DW];
            if (cfg.cfg_addr == AW'(ERR_BASE + k)) rd_data = err_pad[k*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q            <= 1'b0;
            irq_en_q         <= 1'b0;
            gen_q            <= 1'b0;
            pulse_q          <= 1'b0;
            irq_q            <= 1'b0;
            ena_q            <= '0;
            typ_q            <= '0;
            cfg.cfg_dout     <= '0;
            cfg.cfg_dout_vld <= 1'b0;
        end else begin
            run_q   <= run_nxt;
            gen_q   <= status_gen_data;
            pulse_q <= start_go;
            irq_q   <= irq_en_q && ((|err_q) || stk_q[0]);
            if (ctrl_wr) irq_en_q <= cfg.cfg_din[CTRL_IRQ_EN];
            if (!run_q) begin
                ena_q <= ena_nxt;
                typ_q <= typ_nxt;
            end
            cfg.cfg_dout     <= rd ? rd_data : '0;
            cfg.cfg_dout_vld <= rd;
        end
    end

    assign cfg_enable_chid = ena_q;
    assign cfg_type_chid   = typ_q;
    assign cfg_start_pulse = pulse_q;
    assign cfg_run         = run_q;
    assign o_irq           = irq_q;
endmodule

// File: tb/tb_odu_cfg_ctr_gen2.sv
// Directed bench for odu_cfg_ctr_gen2 (16-bit bus, 80 channels).
// Each task drives one scenario and checks hand-computed values.
module tb_odu_cfg_ctr_gen2;
    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] i_error_chid;
    logic        status_gen_data;
    logic [79:0] cfg_enable_chid;
    logic [79:0] cfg_type_chid;
    logic        cfg_start_pulse;
    logic        cfg_run;
    logic        o_irq;

    int n_cmp = 0;
    int n_err = 0;

    odu_cfg_ctr_gen2_if #(.DATA_WIDTH_CFG(16), .ADDR_WIDTH_CFG(5)) bus ();

    odu_cfg_ctr_gen2 #(
        .DATA_WIDTH_CFG (16),
        .ADDR_WIDTH_CFG (5),
        .NUM_CH         (80),
        .ID_VALUE       (16'h0D02)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg             (bus.slave),
        .i_error_chid    (i_error_chid),
        .status_gen_data (status_gen_data),
        .cfg_enable_chid (cfg_enable_chid),
        .cfg_type_chid   (cfg_type_chid),
        .cfg_start_pulse (cfg_start_pulse),
        .cfg_run         (cfg_run),
        .o_irq           (o_irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.cfg_n_cs = 1'b0;
        bus.cfg_n_we = 1'b0;
        bus.cfg_addr = a;
        bus.cfg_din  = d;
        @(posedge clk);
        #1;
        bus.cfg_n_cs = 1'b1;
        bus.cfg_n_we = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [15:0] d,
                      output logic v);
        @(negedge clk);
        bus.cfg_n_cs = 1'b0;
        bus.cfg_n_oe = 1'b0;
        bus.cfg_addr = a;
        @(posedge clk);
        #1;
        d = bus.cfg_dout;
        v = bus.cfg_dout_vld;
        bus.cfg_n_cs = 1'b1;
        bus.cfg_n_oe = 1'b1;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        logic        v;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (cfg_run !== 1'b0 || cfg_enable_chid !== 80'h0
            || bus.cfg_dout_vld !== 1'b0 || o_irq !== 1'b0) begin
            $display("FAIL reset_init: run=%b ena=%h vld=%b irq=%b, want all 0",
                     cfg_run, cfg_enable_chid, bus.cfg_dout_vld, o_irq);
            n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
        wr(5'h04, 16'hFFFF);
        wr(5'h01, 16'h0005);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (cfg_run !== 1'b0 || cfg_start_pulse !== 1'b0
            || cfg_enable_chid !== 80'h0 || o_irq !== 1'b0
            || bus.cfg_dout !== 16'h0 || bus.cfg_dout_vld !== 1'b0) begin
            $display("FAIL reset_async: run=%b pulse=%b ena=%h irq=%b dout=%h vld=%b, want all 0",
                     cfg_run, cfg_start_pulse, cfg_enable_chid, o_irq,
                     bus.cfg_dout, bus.cfg_dout_vld);
            n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
        rd(5'h00, d, v);
        n_cmp++;
        if (d !== 16'h0D02 || v !== 1'b1) begin
            $display("FAIL id_read: got %h vld=%b, want 0d02 vld=1", d, v);
            n_err++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.cfg_dout_vld !== 1'b0 || bus.cfg_dout !== 16'h0) begin
            $display("FAIL idle_dout: got %h vld=%b, want 0000 vld=0",
                     bus.cfg_dout, bus.cfg_dout_vld);
            n_err++;
        end
    endtask

    task automatic test_ena_map;
        logic [15:0] d;
        logic        v;
        wr(5'h04, 16'hFFFF);
        wr(5'h08, 16'hFFFF);
        wr(5'h09, 16'hFFFF);
        n_cmp++;
        if (cfg_enable_chid !== 80'hFFFF_0000_0000_0000_FFFF) begin
            $display("FAIL ena_words: got %h, want ffff00000000_0000ffff",
                     cfg_enable_chid);
            n_err++;
        end
        rd(5'h09, d, v);
        n_cmp++;
        if (d !== 16'h0 || v !== 1'b1) begin
            $display("FAIL unmapped_09: got %h vld=%b, want 0000 vld=1", d, v);
            n_err++;
        end
        wr(5'h0C, 16'h00A5);
        n_cmp++;
        if (cfg_type_chid !== 80'h00A5) begin
            $display("FAIL typ_word0: got %h, want a5", cfg_type_chid);
            n_err++;
        end
        // read and write of the same word in one cycle
        @(negedge clk);
        bus.cfg_n_cs = 1'b0;
        bus.cfg_n_we = 1'b0;
        bus.cfg_n_oe = 1'b0;
        bus.cfg_addr = 5'h04;
        bus.cfg_din  = 16'h00FF;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.cfg_dout !== 16'hFFFF || bus.cfg_dout_vld !== 1'b1
            || cfg_enable_chid !== 80'hFFFF_0000_0000_0000_00FF) begin
            $display("FAIL rd_wr_same: dout=%h vld=%b ena=%h, want ffff 1 ffff..00ff",
                     bus.cfg_dout, bus.cfg_dout_vld, cfg_enable_chid);
            n_err++;
        end
        bus.cfg_n_cs = 1'b1;
        bus.cfg_n_we = 1'b1;
        bus.cfg_n_oe = 1'b1;
    endtask

    task automatic test_run;
        logic [15:0] d;
        logic        v;
        @(negedge clk);
        status_gen_data = 1'b1;
        wr(5'h01, 16'h0001);
        n_cmp++;
        if (cfg_start_pulse !== 1'b1 || cfg_run !== 1'b1) begin
            $display("FAIL start: pulse=%b run=%b, want 1 1",
                     cfg_start_pulse, cfg_run);
            n_err++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (cfg_start_pulse !== 1'b0 || cfg_run !== 1'b1) begin
            $display("FAIL pulse_width: pulse=%b run=%b, want 0 1",
                     cfg_start_pulse, cfg_run);
            n_err++;
        end
        wr(5'h04, 16'h1234);
        n_cmp++;
        if (cfg_enable_chid !== 80'hFFFF_0000_0000_0000_00FF) begin
            $display("FAIL lock_drop: ena=%h, want ffff..00ff", cfg_enable_chid);
            n_err++;
        end
        rd(5'h02, d, v);
        n_cmp++;
        if (d !== 16'h0013 || v !== 1'b1) begin
            $display("FAIL status_run: got %h vld=%b, want 0013 vld=1", d, v);
            n_err++;
        end
        @(negedge clk);
        status_gen_data = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (cfg_run !== 1'b0) begin
            $display("FAIL gen_fall_run: run=%b, want 0", cfg_run);
            n_err++;
        end
        rd(5'h02, d, v);
        n_cmp++;
        if (d !== 16'h0018) begin
            $display("FAIL status_done: got %h, want 0018", d);
            n_err++;
        end
        n_cmp++;
        if (o_irq !== 1'b0) begin
            $display("FAIL irq_masked: got %b, want 0", o_irq);
            n_err++;
        end
        wr(5'h02, 16'h0018);
        rd(5'h02, d, v);
        n_cmp++;
        if (d !== 16'h0000) begin
            $display("FAIL status_w1c: got %h, want 0000", d);
            n_err++;
        end
    endtask

    task automatic test_err_irq;
        logic [15:0] d;
        logic        v;
        wr(5'h01, 16'h0004);
        @(negedge clk);
        i_error_chid[79] = 1'b1;
        @(negedge clk);
        i_error_chid = '0;
        n_cmp++;
        if (o_irq !== 1'b0) begin
            $display("FAIL irq_latency: irq=%b one edge after error, want 0", o_irq);
            n_err++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (o_irq !== 1'b1) begin
            $display("FAIL irq_set: irq=%b, want 1", o_irq);
            n_err++;
        end
        rd(5'h18, d, v);
        n_cmp++;
        if (d !== 16'h8000) begin
            $display("FAIL err_ch79: got %h, want 8000", d);
            n_err++;
        end
        wr(5'h18, 16'h8000);
        @(posedge clk);
        #1;
        n_cmp++;
        if (o_irq !== 1'b0) begin
            $display("FAIL irq_clear: irq=%b, want 0", o_irq);
            n_err++;
        end
        rd(5'h18, d, v);
        n_cmp++;
        if (d !== 16'h0000) begin
            $display("FAIL err_w1c: got %h, want 0000", d);
            n_err++;
        end
    endtask

    task automatic test_set_wins;
        logic [15:0] d;
        logic        v;
        @(negedge clk);
        i_error_chid[3] = 1'b1;
        bus.cfg_n_cs = 1'b0;
        bus.cfg_n_we = 1'b0;
        bus.cfg_addr = 5'h14;
        bus.cfg_din  = 16'h0008;
        @(posedge clk);
        #1;
        bus.cfg_n_cs = 1'b1;
        bus.cfg_n_we = 1'b1;
        i_error_chid = '0;
        rd(5'h14, d, v);
        n_cmp++;
        if (d !== 16'h0008) begin
            $display("FAIL set_wins: got %h, want 0008", d);
            n_err++;
        end
        wr(5'h14, 16'h0008);
        rd(5'h14, d, v);
        n_cmp++;
        if (d !== 16'h0000) begin
            $display("FAIL ch3_clear: got %h, want 0000", d);
            n_err++;
        end
    endtask

    task automatic test_start_stop;
        wr(5'h01, 16'h0003);
        n_cmp++;
        if (cfg_start_pulse !== 1'b0 || cfg_run !== 1'b0) begin
            $display("FAIL start_stop_same: pulse=%b run=%b, want 0 0",
                     cfg_start_pulse, cfg_run);
            n_err++;
        end
        wr(5'h01, 16'h0001);
        n_cmp++;
        if (cfg_start_pulse !== 1'b1 || cfg_run !== 1'b1) begin
            $display("FAIL restart: pulse=%b run=%b, want 1 1",
                     cfg_start_pulse, cfg_run);
            n_err++;
        end
        wr(5'h01, 16'h0001);
        n_cmp++;
        if (cfg_start_pulse !== 1'b0 || cfg_run !== 1'b1) begin
            $display("FAIL start_while_run: pulse=%b run=%b, want 0 1",
                     cfg_start_pulse, cfg_run);
            n_err++;
        end
        wr(5'h01, 16'h0002);
        n_cmp++;
        if (cfg_run !== 1'b0) begin
            $display("FAIL stop: run=%b, want 0", cfg_run);
            n_err++;
        end
    endtask

    initial begin
        rst             = 1'b1;
        i_error_chid    = '0;
        status_gen_data = 1'b0;
        bus.cfg_n_cs    = 1'b1;
        bus.cfg_n_we    = 1'b1;
        bus.cfg_n_oe    = 1'b1;
        bus.cfg_addr    = '0;
        bus.cfg_din     = '0;
        test_reset();
        test_ena_map();
        test_run();
        test_err_irq();
        test_set_wins();
        test_start_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
